// File: rtl/t05_pkg.sv
// Shared types and constants for the translation-stage fetch sequencer.
package t05_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_CHAR,
      RD_CODE,
      READY,
      DONE
   } trn_fetch_state_t;

   localparam logic [3:0] STAGE_TRANSLATE = 4'd5;
   localparam logic [7:0] EOF_CHAR_DEF = 8'h1A;
   localparam int CODE_WORDS = 4;

   // Little-endian byte lane select.
   function automatic logic [7:0] lane_byte(
      input logic [31:0] w,
      input logic [1:0]  sel
   );
      logic [7:0] b;
      unique case (sel)
         2'd0: b = w[7:0];
         2'd1: b = w[15:8];
         2'd2: b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/t05_trn_fetch_ctrl_if.sv
// Shared-SRAM read port: request/address out, one-cycle ack with data in.
interface t05_trn_fetch_ctrl_if;

   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_addr,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/t05_trn_fetch_ctrl_byte_cache.sv
// Single text-word cache: tag/data register, hit compare and lane extract.
module t05_byte_cache
   import t05_pkg::*;
(
   input  logic        clk,
   input  logic        nrst,
   input  logic        clr,
   input  logic        load,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   input  logic [31:0] look_addr,
   output logic        hit,
   output logic [7:0]  look_byte,
   output logic [7:0]  load_byte
);

   logic [31:0] cache_word;
   logic [29:0] cache_tag;
   logic        cache_vld;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         cache_word <= '0;
         cache_tag  <= '0;
         cache_vld  <= 1'b0;
      end else if (clr) begin
         cache_vld <= 1'b0;
      end else if (load) begin
         cache_word <= load_data;
         cache_tag  <= load_addr[31:2];
         cache_vld  <= 1'b1;
      end
   end

   assign hit       = cache_vld && (cache_tag == look_addr[31:2]);
   assign look_byte = lane_byte(cache_word, look_addr[1:0]);
   assign load_byte = lane_byte(load_data, load_addr[1:0]);

endmodule

// File: rtl/t05_trn_fetch_ctrl.sv
// Encode-stage sequencer: fetches each source byte and its 128-bit code
// path from shared SRAM for the translation stage, then presents EOF.
module t05_trn_fetch_ctrl
   import t05_pkg::*;
#(
   parameter logic [31:0] CHAR_BASE = 32'h0000_0000,
   parameter logic [31:0] CODE_BASE = 32'h0000_1000,
   parameter logic [7:0]  EOF_CHAR  = EOF_CHAR_DEF
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic [3:0]   en_state,
   input  logic [31:0]  tot_char,
   input  logic         next_char_req,
   output logic [7:0]   char_out,
   output logic [127:0] path_out,
   output logic         path_valid,
   output logic [3:0]   word_cnt,
   output logic         fetch_done,
   t05_trn_fetch_ctrl_if.master mem
);

   localparam logic [2:0] LAST_K = 3'(CODE_WORDS - 1);

   trn_fetch_state_t state, nxt;

   logic [31:0] char_idx, sel_idx, sel_addr, cur_addr;
   logic [2:0]  code_k;
   logic        exiting, req_q;
   logic [31:0] addr_q;
   logic        stage, ack, abort, rd_state;
   logic        sel_go, sel_eof, sel_hit, clr_out;
   logic        c_hit;
   logic [7:0]  c_look_byte, c_load_byte;

   function automatic logic [31:0] code_addr(input logic [7:0] c);
      return CODE_BASE + {20'b0, c, 4'b0};
   endfunction

   assign mem.mem_req  = req_q;
   assign mem.mem_addr = addr_q;

   always_comb begin
      stage    = (en_state == STAGE_TRANSLATE);
      ack      = mem.mem_ack;
      abort    = exiting || !stage;
      rd_state = (state == RD_CHAR) || (state == RD_CODE);
      sel_go   = stage &&
                 ((state == IDLE) || (state == READY && next_char_req));
      sel_idx  = (state == IDLE) ? '0 : char_idx + 32'd1;
      sel_addr = CHAR_BASE + sel_idx;
      cur_addr = CHAR_BASE + char_idx;
      sel_eof  = (sel_idx == tot_char);
      sel_hit  = c_hit && (state != IDLE);
      clr_out  = (rd_state && ack && abort) ||
                 (!rd_state && !stage);
   end

   t05_byte_cache u_cache (
      .clk       (clk),
      .nrst      (nrst),
      .clr       (state == IDLE && stage),
      .load      (state == RD_CHAR && ack && !abort),
      .load_addr (cur_addr),
      .load_data (mem.mem_rdata),
      .look_addr (sel_addr),
      .hit       (c_hit),
      .look_byte (c_look_byte),
      .load_byte (c_load_byte)
   );

   always_ff @(posedge clk) begin
      if (!nrst) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE, READY: begin
            if (!stage)
               nxt = IDLE;
            else if (sel_go)
               nxt = sel_eof ? DONE : (sel_hit ? RD_CODE : RD_CHAR);
         end
         RD_CHAR:
            if (ack) nxt = abort ? IDLE : RD_CODE;
         RD_CODE:
            if (ack)
               nxt = abort ? IDLE : ((code_k == LAST_K) ? READY : RD_CODE);
         DONE:
            if (!stage) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst || clr_out) begin
         char_idx   <= '0;
         code_k     <= '0;
         exiting    <= 1'b0;
         req_q      <= 1'b0;
         addr_q     <= '0;
         char_out   <= '0;
         path_out   <= '0;
         path_valid <= 1'b0;
         word_cnt   <= '0;
         fetch_done <= 1'b0;
      end else begin
         // A stage exit mid-read is remembered until the pending ack.
         exiting <= rd_state && abort && !ack;
         case (state)
            IDLE, READY, DONE: begin
               if (sel_go) begin
                  char_idx   <= sel_idx;
                  path_valid <= 1'b0;
                  fetch_done <= sel_eof;
                  if (sel_eof) begin
                     char_out <= EOF_CHAR;
                     path_out <= '0;
                     word_cnt <= '0;
                  end else if (sel_hit) begin
                     char_out <= c_look_byte;
                     path_out <= '0;
                     word_cnt <= '0;
                     code_k   <= '0;
                     req_q    <= 1'b1;
                     addr_q   <= code_addr(c_look_byte);
                  end else begin
                     req_q  <= 1'b1;
                     addr_q <= {sel_addr[31:2], 2'b00};
                  end
               end
            end
            RD_CHAR: begin
               if (ack) begin
                  char_out <= c_load_byte;
                  path_out <= '0;
                  word_cnt <= '0;
                  code_k   <= '0;
                  addr_q   <= code_addr(c_load_byte);
               end
            end
            RD_CODE: begin
               if (ack) begin
                  unique case (code_k[1:0])
                     2'd0: path_out[127:96] <= mem.mem_rdata;
                     2'd1: path_out[95:64]  <= mem.mem_rdata;
                     2'd2: path_out[63:32]  <= mem.mem_rdata;
                     default: path_out[31:0] <= mem.mem_rdata;
                  endcase
                  word_cnt <= word_cnt + 4'd1;
                  if (code_k == LAST_K) begin
                     req_q      <= 1'b0;
                     path_valid <= 1'b1;
                  end else begin
                     code_k <= code_k + 3'd1;
                     addr_q <= addr_q + 32'd4;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_t05_trn_fetch_ctrl.sv
// Randomized bench for t05_trn_fetch_ctrl with an SRAM slave and stream model.
module tb_t05_trn_fetch_ctrl;

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic [3:0]   en_state = '0;
   logic [31:0]  tot_char = '0;
   logic         next_char_req = 1'b0;
   logic [7:0]   char_out;
   logic [127:0] path_out;
   logic         path_valid;
   logic [3:0]   word_cnt;
   logic         fetch_done;

   t05_trn_fetch_ctrl_if bus ();

   t05_trn_fetch_ctrl dut (
      .clk           (clk),
      .nrst          (nrst),
      .en_state      (en_state),
      .tot_char      (tot_char),
      .next_char_req (next_char_req),
      .char_out      (char_out),
      .path_out      (path_out),
      .path_valid    (path_valid),
      .word_cnt      (word_cnt),
      .fetch_done    (fetch_done),
      .mem           (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem_words [0:2047];
   int wait_n = 0;
   int wcnt = 0;
   int read_cnt = 0;
   int stab_err = 0;
   int vecs = 0;
   int errs = 0;
   logic pr = 1'b0, pa = 1'b0;
   logic [31:0] paddr = '0;

   assign bus.mem_rdata = mem_words[bus.mem_addr[12:2]];

   // SRAM slave: ack after wait_n idle cycles of a pending request.
   always @(posedge clk) begin
      if (!nrst) begin
         bus.mem_ack <= 1'b0;
         wcnt <= 0;
      end else if (bus.mem_ack) begin
         bus.mem_ack <= 1'b0;
      end else if (bus.mem_req) begin
         if (wcnt == wait_n) begin
            bus.mem_ack <= 1'b1;
            wcnt <= 0;
         end else begin
            wcnt <= wcnt + 1;
         end
      end
   end

   // Bus rule monitor: address held and request kept until acked.
   always @(posedge clk) begin
      if (!nrst) begin
         pr <= 1'b0;
         pa <= 1'b0;
      end else begin
         if (pr && !pa && (!bus.mem_req || bus.mem_addr != paddr))
            stab_err <= stab_err + 1;
         if (bus.mem_req && bus.mem_ack)
            read_cnt <= read_cnt + 1;
         pr <= bus.mem_req;
         pa <= bus.mem_ack;
         paddr <= bus.mem_addr;
      end
   end

   function automatic logic [127:0] model_path(input logic [7:0] c);
      int b;
      b = 'h400 + int'(c) * 4;
      return {mem_words[b], mem_words[b+1], mem_words[b+2], mem_words[b+3]};
   endfunction

   function automatic logic [7:0] model_char(input int i);
      return 8'((mem_words[i / 4] >> (8 * (i % 4))) & 32'hff);
   endfunction

   task automatic wait_pv(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         next_char_req = 1'b0;
      end while (!path_valid && cyc < 300);
   endtask

   task automatic leave();
      en_state = 4'd0;
      next_char_req = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 4; i++) mem_words[i] = $urandom;
      for (int i = 0; i < 16; i++) begin
         int b;
         b = 'h400 + int'(model_char(i)) * 4;
         for (int k = 0; k < 4; k++) mem_words[b + k] = $urandom;
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      repeat (3) @(negedge clk);
      vecs++; if (bus.mem_req !== 1'b0) begin errs++; $display("FAIL rst_req got %b want 0", bus.mem_req); end
      vecs++; if (bus.mem_addr !== 32'h0) begin errs++; $display("FAIL rst_addr got %h want 0", bus.mem_addr); end
      vecs++; if (char_out !== 8'h0) begin errs++; $display("FAIL rst_char got %h want 0", char_out); end
      vecs++; if (path_out !== 128'h0) begin errs++; $display("FAIL rst_path got %h want 0", path_out); end
      vecs++; if ({path_valid, word_cnt, fetch_done} !== 6'h0) begin errs++; $display("FAIL rst_flags got %b want 0", {path_valid, word_cnt, fetch_done}); end
      nrst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_and_eof();
      int cyc, r0;
      mem_words[0] = 32'h0000_0041;
      mem_words['h504] = 32'hA000_0000;
      mem_words['h505] = 32'h0;
      mem_words['h506] = 32'h0;
      mem_words['h507] = 32'h0;
      wait_n = 0;
      r0 = read_cnt;
      tot_char = 32'd1;
      en_state = 4'd5;
      wait_pv(cyc);
      vecs++; if (cyc !== 11) begin errs++; $display("FAIL single_lat got %0d want 11", cyc); end
      vecs++; if (char_out !== 8'h41) begin errs++; $display("FAIL single_char got %h want 41", char_out); end
      vecs++; if (path_out !== {32'hA000_0000, 96'h0}) begin errs++; $display("FAIL single_path got %h want a0000000 then zeros", path_out); end
      vecs++; if (word_cnt !== 4'd4) begin errs++; $display("FAIL single_wcnt got %0d want 4", word_cnt); end
      vecs++; if (read_cnt - r0 !== 5) begin errs++; $display("FAIL single_reads got %0d want 5", read_cnt - r0); end
      next_char_req = 1'b1;
      @(negedge clk);
      next_char_req = 1'b0;
      vecs++; if (path_valid !== 1'b0) begin errs++; $display("FAIL eof_pv got %b want 0", path_valid); end
      vecs++; if (char_out !== 8'h1A) begin errs++; $display("FAIL eof_char got %h want 1a", char_out); end
      vecs++; if (fetch_done !== 1'b1) begin errs++; $display("FAIL eof_done got %b want 1", fetch_done); end
      repeat (6) @(negedge clk);
      vecs++; if (read_cnt - r0 !== 5 || bus.mem_req !== 1'b0) begin errs++; $display("FAIL eof_quiet reads %0d req %b want 5 0", read_cnt - r0, bus.mem_req); end
      vecs++; if (fetch_done !== 1'b1) begin errs++; $display("FAIL eof_sticky got %b want 1", fetch_done); end
      leave();
   endtask

   task automatic test_stream(input int n, input int w);
      int cyc, r0, exp_lat;
      bit miss;
      wait_n = w;
      r0 = read_cnt;
      tot_char = n;
      en_state = 4'd5;
      for (int i = 0; i < n; i++) begin
         if (i > 0) next_char_req = 1'b1;
         wait_pv(cyc);
         miss = (i == 0) || (i / 4 != (i - 1) / 4);
         exp_lat = 1 + (miss ? 5 : 4) * (2 + w);
         vecs++; if (cyc !== exp_lat) begin errs++; $display("FAIL stream_lat[%0d] got %0d want %0d", i, cyc, exp_lat); end
         vecs++; if (char_out !== model_char(i)) begin errs++; $display("FAIL stream_char[%0d] got %h want %h", i, char_out, model_char(i)); end
         vecs++; if (path_out !== model_path(model_char(i))) begin errs++; $display("FAIL stream_path[%0d] got %h want %h", i, path_out, model_path(model_char(i))); end
         vecs++; if (word_cnt !== 4'd4) begin errs++; $display("FAIL stream_wcnt[%0d] got %0d want 4", i, word_cnt); end
      end
      next_char_req = 1'b1;
      @(negedge clk);
      next_char_req = 1'b0;
      vecs++; if ({fetch_done, path_valid, char_out} !== {2'b10, 8'h1A}) begin errs++; $display("FAIL stream_eof got %b %b %h want 1 0 1a", fetch_done, path_valid, char_out); end
      vecs++; if (read_cnt - r0 !== (n + 3) / 4 + 4 * n) begin errs++; $display("FAIL stream_reads got %0d want %0d", read_cnt - r0, (n + 3) / 4 + 4 * n); end
      leave();
   endtask

   task automatic test_abort();
      int cyc, r0, t;
      fill_rand();
      wait_n = 2;
      r0 = read_cnt;
      tot_char = 32'd4;
      en_state = 4'd5;
      t = 0;
      while (read_cnt - r0 < 2 && t < 100) begin
         @(negedge clk);
         t++;
      end
      vecs++; if (read_cnt - r0 !== 2 || bus.mem_req !== 1'b1) begin errs++; $display("FAIL abort_setup reads %0d req %b want 2 1", read_cnt - r0, bus.mem_req); end
      en_state = 4'd4;
      t = 0;
      while (t < 50) begin
         @(negedge clk);
         t++;
         if (read_cnt - r0 >= 3) break;
         vecs++; if (bus.mem_req !== 1'b1) begin errs++; $display("FAIL abort_hold got %b want 1", bus.mem_req); end
      end
      vecs++; if (read_cnt - r0 !== 3) begin errs++; $display("FAIL abort_ack reads %0d want 3", read_cnt - r0); end
      vecs++; if ({bus.mem_req, path_valid, fetch_done, word_cnt, char_out} !== 15'h0 || path_out !== 128'h0) begin errs++; $display("FAIL abort_clear got req %b char %h wcnt %0d path %h want zeros", bus.mem_req, char_out, word_cnt, path_out); end
      repeat (2) @(negedge clk);
      r0 = read_cnt;
      en_state = 4'd5;
      wait_pv(cyc);
      vecs++; if (cyc !== 21) begin errs++; $display("FAIL reenter_lat got %0d want 21", cyc); end
      vecs++; if (char_out !== model_char(0)) begin errs++; $display("FAIL reenter_char got %h want %h", char_out, model_char(0)); end
      vecs++; if (read_cnt - r0 !== 5) begin errs++; $display("FAIL reenter_reads got %0d want 5", read_cnt - r0); end
      leave();
   endtask

   task automatic test_tot0_reset();
      int r0;
      wait_n = 0;
      r0 = read_cnt;
      tot_char = 32'd0;
      en_state = 4'd5;
      @(negedge clk);
      vecs++; if ({fetch_done, path_valid, char_out} !== {2'b10, 8'h1A}) begin errs++; $display("FAIL tot0_eof got %b %b %h want 1 0 1a", fetch_done, path_valid, char_out); end
      repeat (4) @(negedge clk);
      vecs++; if (read_cnt - r0 !== 0 || bus.mem_req !== 1'b0) begin errs++; $display("FAIL tot0_bus reads %0d req %b want 0 0", read_cnt - r0, bus.mem_req); end
      nrst = 1'b0;
      @(negedge clk);
      vecs++; if ({bus.mem_req, path_valid, fetch_done, word_cnt, char_out} !== 15'h0 || path_out !== 128'h0 || bus.mem_addr !== 32'h0) begin errs++; $display("FAIL midrst got req %b done %b char %h addr %h want zeros", bus.mem_req, fetch_done, char_out, bus.mem_addr); end
      en_state = 4'd0;
      nrst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem_words[i] = 32'h0;
      test_reset();
      test_single_and_eof();
      fill_rand();
      mem_words[0] = 32'h6463_6261;
      test_stream(4, 0);
      fill_rand();
      test_stream(int'($urandom_range(2, 9)), 3);
      fill_rand();
      test_stream(int'($urandom_range(5, 12)), int'($urandom_range(0, 2)));
      test_abort();
      test_tot0_reset();
      vecs++; if (stab_err !== 0) begin errs++; $display("FAIL bus_rule got %0d violations want 0", stab_err); end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
